ram_port_arbiter: RTL and testbench

- Front-end scheduler for the 4-port 16x8 RAM. Four requesters (0..3) each own one RAM port (requester i drives port a/b/c/d).
- Resolves same-cycle hazards the RAM does not handle: write-write collisions to one address, and read-during-write to one address by different ports.
- Uses a round-robin priority pointer and a valid/ready handshake per requester.
- Returns read data with a registered response-valid strobe.

---
 rtl/ram_port_arbiter_pkg.sv | 29 ++
 rtl/ram_port_arbiter_if.sv | 28 ++
 rtl/ram_port_arbiter_rr_conflict_resolver.sv | 53 +++++
 rtl/ram_port_arbiter.sv | 88 ++++++++
 tb/tb_ram_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared widths, request record and round-robin helper for the 4-port RAM front-end arbiter.
package ram_port_arbiter_pkg;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 16;

  typedef logic [$clog2(NREQ)-1:0] idx_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Bit k of the result is vec[(ptr + k) mod NREQ], i.e. bit 0 is the highest-priority requester.
  function automatic logic [NREQ-1:0] rr_rotate(input logic [NREQ-1:0] vec, input idx_t ptr);
    logic [NREQ-1:0] r;
    idx_t            s;
    r = '0;
    for (int k = 0; k < NREQ; k++) begin
      s    = ptr + idx_t'(k);
      r[k] = vec[s];
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester, response and RAM-side signal bundle of the arbiter.
interface ram_port_arbiter_if;
  import ram_port_arbiter_pkg::*;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_we;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        rsp_valid;
  logic [NREQ*DATA_W-1:0] rsp_rdata;
  logic [NREQ-1:0]        ram_we;
  logic [NREQ*ADDR_W-1:0] ram_addr;
  logic [NREQ*DATA_W-1:0] ram_din;
  logic [NREQ*DATA_W-1:0] ram_dout;
  logic [CNT_W-1:0]       stall_cnt;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, ram_dout,
    output req_ready, rsp_valid, rsp_rdata, ram_we, ram_addr, ram_din, stall_cnt
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, ram_dout,
    input  req_ready, rsp_valid, rsp_rdata, ram_we, ram_addr, ram_din, stall_cnt
  );

endinterface

// File: rtl/ram_port_arbiter_rr_conflict_resolver.sv
// Combinational priority scan: grants requesters in round-robin order, skipping address hazards.
module rr_conflict_resolver
  import ram_port_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]   valid_i,
  input  logic [NREQ-1:0]   we_i,
  input  logic [ADDR_W-1:0] addr_i [NREQ],
  input  idx_t              ptr_i,
  output logic [NREQ-1:0]   granted_o,
  output logic [NREQ-1:0]   stall_o,
  output logic              any_stall_o,
  output idx_t              first_stall_idx_o
);

  logic [NREQ-1:0] granted;
  logic [NREQ-1:0] stall_rot;
  idx_t            cur;
  logic            clash;

  always_comb begin
    granted = '0;
    cur     = '0;
    clash   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cur   = ptr_i + idx_t'(k);
      clash = 1'b0;
      // Read-read to one address is safe; any write involvement against an earlier grant is not.
      for (int j = 0; j < NREQ; j++) begin
        if (granted[j] && (addr_i[j] == addr_i[cur]) && (we_i[j] || we_i[cur])) begin
          clash = 1'b1;
        end
      end
      if (valid_i[cur] && !clash) begin
        granted[cur] = 1'b1;
      end
    end
  end

  always_comb begin
    stall_rot         = rr_rotate(valid_i & ~granted, ptr_i);
    first_stall_idx_o = ptr_i;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (stall_rot[k]) begin
        first_stall_idx_o = ptr_i + idx_t'(k);
      end
    end
  end

  assign granted_o   = granted;
  assign stall_o     = valid_i & ~granted;
  assign any_stall_o = |stall_o;

endmodule

// File: rtl/ram_port_arbiter.sv
// Hazard-resolving round-robin front-end for a 4-port RAM with registered read-response strobes.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  ram_port_arbiter_if.slave  bus
);

  localparam int unsigned PopW = $clog2(NREQ) + 1;
  localparam int unsigned SumW = CNT_W + 1;

  req_t              req [NREQ];
  logic [ADDR_W-1:0] req_addr [NREQ];
  logic [NREQ-1:0]   valid_eff;
  logic [NREQ-1:0]   granted;
  logic [NREQ-1:0]   stall;
  logic              any_stall;
  idx_t              first_stall_idx;

  idx_t              rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [PopW-1:0]   pop;
  logic [SumW-1:0]   sum;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req[i].we    = bus.req_we[i];
      req[i].addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
      req[i].wdata = bus.req_wdata[i*DATA_W +: DATA_W];
      req_addr[i]  = req[i].addr;
    end
  end

  // Nothing is granted (and so nothing written) while reset is held.
  assign valid_eff = bus.req_valid & {NREQ{rst_n}};

  rr_conflict_resolver u_resolver (
    .valid_i           (valid_eff),
    .we_i              (bus.req_we),
    .addr_i            (req_addr),
    .ptr_i             (rr_ptr_q),
    .granted_o         (granted),
    .stall_o           (stall),
    .any_stall_o       (any_stall),
    .first_stall_idx_o (first_stall_idx)
  );

  always_comb begin
    bus.ram_addr = '0;
    bus.ram_din  = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.ram_addr[i*ADDR_W +: ADDR_W] = req[i].addr;
      bus.ram_din[i*DATA_W +: DATA_W]  = req[i].wdata;
    end
  end

  assign bus.req_ready = granted;
  assign bus.ram_we    = granted & bus.req_we;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = bus.ram_dout;
  assign bus.stall_cnt = stall_cnt_q;

  always_comb begin
    pop = '0;
    for (int k = 0; k < NREQ; k++) begin
      pop = pop + PopW'(stall[k]);
    end
    sum         = {1'b0, stall_cnt_q} + SumW'(pop);
    stall_cnt_d = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    rsp_valid_d = granted & ~bus.req_we;
    rr_ptr_d    = any_stall ? first_stall_idx : rr_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      rsp_valid_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 16x8 4-port RAM behind it.
module tb_ram_port_arbiter;
  import ram_port_arbiter_pkg::*;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic [7:0] mem [16];

  ram_port_arbiter_if bus ();

  ram_port_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1-cycle-latency RAM, read returns the pre-write contents.
  always @(posedge clk) begin
    for (int p = 0; p < 4; p++) begin
      bus.ram_dout[p*8 +: 8] <= mem[bus.ram_addr[p*4 +: 4]];
      if (bus.ram_we[p]) mem[bus.ram_addr[p*4 +: 4]] <= bus.ram_din[p*8 +: 8];
    end
  end

  task automatic set_req(input int i, input logic v, input logic we, input logic [3:0] a,
                         input logic [7:0] d);
    bus.req_valid[i]         = v;
    bus.req_we[i]            = we;
    bus.req_addr[i*4 +: 4]   = a;
    bus.req_wdata[i*8 +: 8]  = d;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_reqs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b1, 4'(i), 8'hEE);
    #1;
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      errors++; $display("FAIL rst_ready: got %b expected %b", bus.req_ready, 4'b0000);
    end
    checks++;
    if (bus.ram_we !== 4'b0000) begin
      errors++; $display("FAIL rst_ram_we: got %b expected %b", bus.ram_we, 4'b0000);
    end
    checks++;
    if (bus.rsp_valid !== 4'b0000 || bus.stall_cnt !== 16'd0 || dut.rr_ptr_q !== 2'd0) begin
      errors++;
      $display("FAIL rst_regs: got rsp=%b cnt=%0d ptr=%0d expected 0 0 0",
               bus.rsp_valid, bus.stall_cnt, dut.rr_ptr_q);
    end
    clear_reqs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_collision_free();
    do_reset();
    set_req(0, 1'b1, 1'b1, 4'd1, 8'h11);
    set_req(1, 1'b1, 1'b1, 4'd2, 8'h22);
    set_req(2, 1'b1, 1'b1, 4'd3, 8'h33);
    set_req(3, 1'b1, 1'b1, 4'd4, 8'h44);
    #1;
    checks++;
    if (bus.req_ready !== 4'b1111) begin
      errors++; $display("FAIL cf_ready: got %b expected %b", bus.req_ready, 4'b1111);
    end
    checks++;
    if (bus.ram_we !== 4'b1111) begin
      errors++; $display("FAIL cf_ram_we: got %b expected %b", bus.ram_we, 4'b1111);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.stall_cnt !== 16'd0 || dut.rr_ptr_q !== 2'd0) begin
      errors++;
      $display("FAIL cf_cnt_ptr: got cnt=%0d ptr=%0d expected 0 0", bus.stall_cnt, dut.rr_ptr_q);
    end
    checks++;
    if (mem[4] !== 8'h44 || mem[1] !== 8'h11) begin
      errors++; $display("FAIL cf_mem: got %h %h expected 11 44", mem[1], mem[4]);
    end
    @(negedge clk);
    clear_reqs();
  endtask

  task automatic test_write_collision();
    do_reset();
    set_req(1, 1'b1, 1'b1, 4'd5, 8'hAA);
    set_req(3, 1'b1, 1'b1, 4'd5, 8'hBB);
    #1;
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      errors++; $display("FAIL ww_ready0: got %b expected %b", bus.req_ready, 4'b0010);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.stall_cnt !== 16'd1 || dut.rr_ptr_q !== 2'd3) begin
      errors++;
      $display("FAIL ww_cnt_ptr: got cnt=%0d ptr=%0d expected 1 3", bus.stall_cnt, dut.rr_ptr_q);
    end
    @(negedge clk);
    set_req(1, 1'b0, 1'b0, 4'd0, 8'h00);
    #1;
    checks++;
    if (bus.req_ready !== 4'b1000 || bus.ram_we !== 4'b1000) begin
      errors++;
      $display("FAIL ww_ready1: got rdy=%b we=%b expected 1000 1000", bus.req_ready, bus.ram_we);
    end
    @(negedge clk);
    clear_reqs();
    set_req(0, 1'b1, 1'b0, 4'd5, 8'h00);
    @(posedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 4'b0001 || bus.rsp_rdata[7:0] !== 8'hBB) begin
      errors++;
      $display("FAIL ww_readback: got v=%b d=%h expected 0001 bb",
               bus.rsp_valid, bus.rsp_rdata[7:0]);
    end
    @(negedge clk);
    clear_reqs();
  endtask

  task automatic test_read_write_hazard();
    do_reset();
    set_req(0, 1'b1, 1'b1, 4'd7, 8'h5C);
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 4'd7, 8'h00);
    set_req(2, 1'b1, 1'b1, 4'd7, 8'h99);
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001 || bus.ram_we !== 4'b0000) begin
      errors++;
      $display("FAIL rw_ready0: got rdy=%b we=%b expected 0001 0000", bus.req_ready, bus.ram_we);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 4'b0001 || bus.rsp_rdata[7:0] !== 8'h5C) begin
      errors++;
      $display("FAIL rw_rsp: got v=%b d=%h expected 0001 5c", bus.rsp_valid, bus.rsp_rdata[7:0]);
    end
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 4'd0, 8'h00);
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100 || bus.ram_we !== 4'b0100) begin
      errors++;
      $display("FAIL rw_ready1: got rdy=%b we=%b expected 0100 0100", bus.req_ready, bus.ram_we);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 4'b0000 || mem[7] !== 8'h99 || bus.stall_cnt !== 16'd1) begin
      errors++;
      $display("FAIL rw_after: got v=%b mem=%h cnt=%0d expected 0000 99 1",
               bus.rsp_valid, mem[7], bus.stall_cnt);
    end
    @(negedge clk);
    clear_reqs();
  endtask

  task automatic test_read_read();
    do_reset();
    set_req(0, 1'b1, 1'b1, 4'd9, 8'h3E);
    @(negedge clk);
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 4'd9, 8'h00);
    #1;
    checks++;
    if (bus.req_ready !== 4'b1111) begin
      errors++; $display("FAIL rr_ready: got %b expected %b", bus.req_ready, 4'b1111);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 4'b1111 || bus.rsp_rdata !== {4{8'h3E}}) begin
      errors++;
      $display("FAIL rr_rsp: got v=%b d=%h expected 1111 3e3e3e3e", bus.rsp_valid, bus.rsp_rdata);
    end
    @(negedge clk);
    clear_reqs();
    @(posedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 4'b0000) begin
      errors++; $display("FAIL idle_rsp: got %b expected %b", bus.rsp_valid, 4'b0000);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp;
    do_reset();
    set_req(1, 1'b1, 1'b1, 4'd0, 8'h01);
    set_req(2, 1'b1, 1'b1, 4'd0, 8'h02);
    for (int c = 0; c < 8; c++) begin
      exp = (c % 2 == 0) ? 4'b0010 : 4'b0100;
      #1;
      checks++;
      if (bus.req_ready !== exp) begin
        errors++; $display("FAIL fair_ready[%0d]: got %b expected %b", c, bus.req_ready, exp);
      end
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (bus.stall_cnt !== 16'd8) begin
      errors++; $display("FAIL fair_cnt: got %0d expected 8", bus.stall_cnt);
    end
    clear_reqs();
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    set_req(0, 1'b1, 1'b1, 4'd6, 8'h60);
    set_req(1, 1'b1, 1'b0, 4'd8, 8'h00);
    set_req(3, 1'b1, 1'b1, 4'd6, 8'h63);
    #1;
    checks++;
    if (bus.req_ready !== 4'b0011) begin
      errors++; $display("FAIL mid_ready0: got %b expected %b", bus.req_ready, 4'b0011);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 4'b0010 || bus.stall_cnt !== 16'd1 || dut.rr_ptr_q !== 2'd3) begin
      errors++;
      $display("FAIL mid_pre: got v=%b cnt=%0d ptr=%0d expected 0010 1 3",
               bus.rsp_valid, bus.stall_cnt, dut.rr_ptr_q);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rsp_valid !== 4'b0000 || bus.stall_cnt !== 16'd0 || dut.rr_ptr_q !== 2'd0) begin
      errors++;
      $display("FAIL mid_rst: got v=%b cnt=%0d ptr=%0d expected 0000 0 0",
               bus.rsp_valid, bus.stall_cnt, dut.rr_ptr_q);
    end
    checks++;
    if (bus.req_ready !== 4'b0000 || bus.ram_we !== 4'b0000) begin
      errors++;
      $display("FAIL mid_rst_comb: got rdy=%b we=%b expected 0000 0000", bus.req_ready, bus.ram_we);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0011) begin
      errors++; $display("FAIL mid_after: got %b expected %b", bus.req_ready, 4'b0011);
    end
    @(posedge clk); #1;
    checks++;
    if (mem[6] !== 8'h60 || bus.stall_cnt !== 16'd1) begin
      errors++;
      $display("FAIL mid_win: got mem=%h cnt=%0d expected 60 1", mem[6], bus.stall_cnt);
    end
    @(negedge clk);
    clear_reqs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    errors = 0;
    checks = 0;
    for (int a = 0; a < 16; a++) mem[a] = 8'h00;
    bus.ram_dout = '0;
    rst_n = 1'b0;
    clear_reqs();
    test_reset();
    test_collision_free();
    test_write_collision();
    test_read_write_hazard();
    test_read_read();
    test_fairness();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
